// File: rtl/cv32e40p_lce_marker_injector_if.sv
// Fetch-side and ID-side handshake bundle for the LCE marker injector.
interface cv32e40p_lce_marker_injector_if;
  logic        fetch_valid_i;
  logic [31:0] fetch_rdata_i;
  logic        fetch_ready_o;
  logic        instr_valid_o;
  logic [31:0] instr_rdata_o;
  logic        instr_ready_i;
  logic        flush_i;
  logic        inj_active_o;

  modport slave (
    input  fetch_valid_i, fetch_rdata_i, instr_ready_i, flush_i,
    output fetch_ready_o, instr_valid_o, instr_rdata_o, inj_active_o
  );

  modport master (
    output fetch_valid_i, fetch_rdata_i, instr_ready_i, flush_i,
    input  fetch_ready_o, instr_valid_o, instr_rdata_o, inj_active_o
  );
endinterface

// File: rtl/cv32e40p_lce_marker_injector.sv
// One-entry fetch->ID stage that inserts MARKER so ID never sees MAX_BB_LEN non-marker words in a row.
// Optional injected-marker counter port inj_count_o when CV32E40P_LCE_INJ_STATS_EN is defined.
module cv32e40p_lce_marker_injector #(
  parameter int unsigned MAX_BB_LEN = 16,
  parameter logic [31:0] MARKER     = 32'h0000006f
) (
  input  logic clk,
  input  logic rst_n,
`ifdef CV32E40P_LCE_INJ_STATS_EN
  output logic [15:0] inj_count_o,
`endif
  cv32e40p_lce_marker_injector_if.slave bus
);

  localparam int unsigned CW = $clog2(MAX_BB_LEN);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_BB_LEN - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic [1:0] {
    EMPTY       = 2'd0,
    FULL_INSTR  = 2'd1,
    FULL_MARKER = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          occupied_s, is_marker_s, handoff_s, load_slot_s, inj_s;

  // Decode the held word, then derive handoff, run-length update and injection
  always_comb begin
    occupied_s  = 1'b0;
    is_marker_s = 1'b0;
    case (state_q)
      EMPTY: begin
        occupied_s  = 1'b0;
        is_marker_s = 1'b0;
      end
      FULL_INSTR: begin
        occupied_s  = 1'b1;
        is_marker_s = (rdata_q == MARKER);
      end
      FULL_MARKER: begin
        occupied_s  = 1'b1;
        is_marker_s = 1'b1;
      end
      default: begin
        occupied_s  = 1'b0;
        is_marker_s = 1'b0;
      end
    endcase

    handoff_s = occupied_s & bus.instr_ready_i;

    // Any marker reaching ID restarts the run; the run saturates just in case
    if (!handoff_s) begin
      cnt_d = cnt_q;
    end else if (is_marker_s) begin
      cnt_d = CNT_ZERO;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end

    load_slot_s = (~occupied_s | handoff_s) & ~bus.flush_i;
    inj_s       = load_slot_s & (cnt_d == CNT_MAX);
  end

  // Next-state and load selection; flush takes priority over any load
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    if (bus.flush_i) begin
      state_d = EMPTY;
    end else if (inj_s) begin
      state_d = FULL_MARKER;
      rdata_d = MARKER;
    end else if (load_slot_s) begin
      if (bus.fetch_valid_i) begin
        state_d = FULL_INSTR;
        rdata_d = bus.fetch_rdata_i;
      end else begin
        state_d = EMPTY;
      end
    end else begin
      state_d = state_q;
    end
  end

  // Stage and run-length registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      cnt_q   <= CNT_ZERO;
      rdata_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.fetch_ready_o = load_slot_s & ~inj_s;
  assign bus.instr_valid_o = (state_q != EMPTY);
  assign bus.instr_rdata_o = rdata_q;
  assign bus.inj_active_o  = (state_q == FULL_MARKER);

`ifdef CV32E40P_LCE_INJ_STATS_EN
  logic [15:0] inj_count_q;

  // Saturating count of injected markers handed to ID
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inj_count_q <= 16'h0000;
    end else if (handoff_s && (state_q == FULL_MARKER) && (inj_count_q != 16'hFFFF)) begin
      inj_count_q <= inj_count_q + 16'h0001;
    end else begin
      inj_count_q <= inj_count_q;
    end
  end

  assign inj_count_o = inj_count_q;
`endif

endmodule

// File: tb/tb_cv32e40p_lce_marker_injector.sv
// Self-checking bench for cv32e40p_lce_marker_injector with MAX_BB_LEN=4.
module tb_cv32e40p_lce_marker_injector;
  localparam int          MAXL = 4;
  localparam logic [31:0] MK   = 32'h0000006f;
  localparam logic [31:0] WA   = 32'h0000_1013;
  localparam logic [31:0] WB   = 32'h0000_2013;
  localparam logic [31:0] WC   = 32'h0000_3013;
  localparam logic [31:0] WD   = 32'h0000_4013;
  localparam logic [31:0] WE   = 32'h0000_5013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  cv32e40p_lce_marker_injector_if bus_if ();
`ifdef CV32E40P_LCE_INJ_STATS_EN
  logic [15:0] inj_count;
`endif

  cv32e40p_lce_marker_injector #(.MAX_BB_LEN(MAXL), .MARKER(MK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef CV32E40P_LCE_INJ_STATS_EN
    .inj_count_o(inj_count),
`endif
    .bus        (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Model state: accepted-but-undelivered words, non-marker run length, words ID received
  logic [31:0] acc_q[$];
  logic [31:0] delivered[$];
  int          run = 0;
  logic        hold_pend = 1'b0, lat_pend = 1'b0, hand, acc, exp_inj;
  logic [31:0] held_word, exp_w;

  // Reference model and compare process, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      acc_q.delete();
      run = 0;
      hold_pend = 1'b0;
      lat_pend = 1'b0;
    end else begin
      if (lat_pend) chk("latency_valid", 32'(bus_if.instr_valid_o), 32'd1);
      if (hold_pend) begin
        chk("hold_valid", 32'(bus_if.instr_valid_o), 32'd1);
        chk("hold_data", bus_if.instr_rdata_o, held_word);
      end
      hand = bus_if.instr_valid_o & bus_if.instr_ready_i;
      acc  = bus_if.fetch_valid_i & bus_if.fetch_ready_o;
      if (hand) begin
        if (run == MAXL - 1) begin
          exp_w = MK; exp_inj = 1'b1;
        end else if (acc_q.size() == 0) begin
          exp_w = 32'hxxxx_xxxx; exp_inj = 1'b0;
          tests_run++; tests_failed++;
          $display("FAIL unexpected_handoff actual=%h required=none", bus_if.instr_rdata_o);
        end else begin
          exp_w = acc_q.pop_front(); exp_inj = 1'b0;
        end
        if (!$isunknown(exp_w)) begin
          chk("handoff_data", bus_if.instr_rdata_o, exp_w);
          chk("handoff_inj", 32'(bus_if.inj_active_o), 32'(exp_inj));
          run = (exp_w == MK) ? 0 : run + 1;
        end
        delivered.push_back(bus_if.instr_rdata_o);
      end
      if (bus_if.flush_i) begin
        chk("flush_blocks_fetch", 32'(bus_if.fetch_ready_o), 32'd0);
        acc_q.delete();
      end
      if (acc) acc_q.push_back(bus_if.fetch_rdata_i);
      lat_pend  = acc;
      hold_pend = bus_if.instr_valid_o & ~hand & ~bus_if.flush_i;
      held_word = bus_if.instr_rdata_o;
    end
  end

  task automatic reset_dut();
    rst_n = 1'b0;
    bus_if.fetch_valid_i = 1'b0;
    bus_if.fetch_rdata_i = 32'h0;
    bus_if.instr_ready_i = 1'b1;
    bus_if.flush_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    delivered.delete();
  endtask

  logic [31:0] stim[$];
  logic [31:0] exp_seq[$];

  task automatic send_words(output int bubbles);
    int i = 0;
    int guard = 0;
    bubbles = 0;
    while (i < stim.size() && guard < 100) begin
      bus_if.fetch_valid_i = 1'b1;
      bus_if.fetch_rdata_i = stim[i];
      @(negedge clk);
      if (bus_if.fetch_ready_o) i++;
      else bubbles++;
      @(posedge clk); #1;
      guard++;
    end
    bus_if.fetch_valid_i = 1'b0;
    if (guard >= 100) begin
      tests_run++; tests_failed++;
      $display("FAIL send_timeout actual=%0d required=%0d", i, stim.size());
    end
  endtask

  task automatic idle(input int n);
    bus_if.fetch_valid_i = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic chk_seq(input string nm);
    chk({nm, "_len"}, 32'(delivered.size()), 32'(exp_seq.size()));
    for (int i = 0; i < exp_seq.size() && i < delivered.size(); i++)
      chk(nm, delivered[i], exp_seq[i]);
  endtask

  int bub;

  initial begin
    bus_if.fetch_valid_i = 1'b0;
    bus_if.fetch_rdata_i = 32'h0;
    bus_if.instr_ready_i = 1'b1;
    bus_if.flush_i = 1'b0;

    // Reset state
    reset_dut();
    @(negedge clk);
    chk("rst_valid", 32'(bus_if.instr_valid_o), 32'd0);
    chk("rst_rdata", bus_if.instr_rdata_o, 32'h0);
    chk("rst_inj", 32'(bus_if.inj_active_o), 32'd0);
    chk("rst_ready", 32'(bus_if.fetch_ready_o), 32'd1);
`ifdef CV32E40P_LCE_INJ_STATS_EN
    chk("rst_inj_count", 32'(inj_count), 32'd0);
`endif
    @(posedge clk); #1;

    // Streaming: A..E gives A,B,C,MARKER,D,E with one fetch bubble
    reset_dut();
    stim = '{WA, WB, WC, WD, WE};
    send_words(bub);
    idle(6);
    chk("stream_bubbles", 32'(bub), 32'd1);
    exp_seq = '{WA, WB, WC, MK, WD, WE};
    chk_seq("stream_seq");
`ifdef CV32E40P_LCE_INJ_STATS_EN
    chk("stream_inj_count", 32'(inj_count), 32'd1);
`endif

    // Natural marker restarts the run; injection falls after E
    reset_dut();
    stim = '{WA, WB, MK, WC, WD, WE};
    send_words(bub);
    idle(6);
    chk("natural_bubbles", 32'(bub), 32'd0);
    exp_seq = '{WA, WB, MK, WC, WD, WE, MK};
    chk_seq("natural_seq");

    // Backpressure: A held for 5 cycles, run length unchanged
    reset_dut();
    bus_if.instr_ready_i = 1'b0;
    stim = '{WA};
    send_words(bub);
    bus_if.fetch_valid_i = 1'b1;
    bus_if.fetch_rdata_i = WB;
    repeat (5) begin
      @(negedge clk);
      chk("bp_ready", 32'(bus_if.fetch_ready_o), 32'd0);
      chk("bp_rdata", bus_if.instr_rdata_o, WA);
      @(posedge clk); #1;
    end
    bus_if.instr_ready_i = 1'b1;
    stim = '{WB, WC};
    send_words(bub);
    idle(6);
    exp_seq = '{WA, WB, WC, MK};
    chk_seq("bp_seq");

    // Flush drops held B; run stays at 1
    reset_dut();
    bus_if.fetch_valid_i = 1'b1; bus_if.fetch_rdata_i = WA;
    @(posedge clk); #1;
    bus_if.fetch_rdata_i = WB;
    @(posedge clk); #1;
    bus_if.fetch_valid_i = 1'b0; bus_if.instr_ready_i = 1'b0; bus_if.flush_i = 1'b1;
    @(posedge clk); #1;
    bus_if.flush_i = 1'b0; bus_if.instr_ready_i = 1'b1;
    @(negedge clk);
    chk("flush_valid", 32'(bus_if.instr_valid_o), 32'd0);
    @(posedge clk); #1;
    stim = '{WC, WD};
    send_words(bub);
    idle(6);
    exp_seq = '{WA, WC, WD, MK};
    chk_seq("flush_seq");

    // Flush coinciding with injection: marker deferred to first slot after flush
    reset_dut();
    bus_if.fetch_valid_i = 1'b1; bus_if.fetch_rdata_i = WA;
    @(posedge clk); #1;
    bus_if.fetch_rdata_i = WB;
    @(posedge clk); #1;
    bus_if.fetch_rdata_i = WC;
    @(posedge clk); #1;
    bus_if.fetch_valid_i = 1'b0; bus_if.flush_i = 1'b1;
    @(negedge clk);
    chk("finj_ready0", 32'(bus_if.fetch_ready_o), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("finj_valid1", 32'(bus_if.instr_valid_o), 32'd0);
    @(posedge clk); #1;
    bus_if.flush_i = 1'b0; bus_if.instr_ready_i = 1'b0;
    @(negedge clk);
    chk("finj_valid2", 32'(bus_if.instr_valid_o), 32'd0);
    chk("finj_ready2", 32'(bus_if.fetch_ready_o), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("finj_marker_inj", 32'(bus_if.inj_active_o), 32'd1);
    chk("finj_marker_data", bus_if.instr_rdata_o, MK);
    exp_seq = '{WA, WB, WC};
    chk_seq("finj_seq");

    // Reset while an injected marker is held
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("rstmid_valid", 32'(bus_if.instr_valid_o), 32'd0);
    chk("rstmid_inj", 32'(bus_if.inj_active_o), 32'd0);
`ifdef CV32E40P_LCE_INJ_STATS_EN
    chk("rstmid_inj_count", 32'(inj_count), 32'd0);
`endif
    reset_dut();
    stim = '{WA, WB, WC, WD};
    send_words(bub);
    idle(6);
    exp_seq = '{WA, WB, WC, MK, WD};
    chk_seq("rstmid_seq");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/cv32e40p_lce_marker_injector.md
# cv32e40p_lce_marker_injector

Marker source for loop/control-flow-escape (LCE) protection. Sits between the prefetch buffer output and the IF/ID register and forwards fetched instruction words through a one-entry registered stage. It inserts the marker word 32'h0000006f into the stream so that no more than MAX_BB_LEN-1 consecutive non-marker words reach ID. The LCE detector in ID therefore never alarms on legal code when both blocks share the same MAX_BB_LEN.

## Interface
- MAX_BB_LEN, 16: maximum basic-block length enforced by the paired detector. Must be ≥2.
- MARKER, 32'h0000006f: marker instruction word. Must match the detector's marker.
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- fetch_valid_i  in  1  prefetch word valid.
- fetch_rdata_i  in  32  prefetch instruction word.
- fetch_ready_o  out  1  word accepted when fetch_valid_i & fetch_ready_o.
- instr_valid_o  out  1  output stage holds a word for ID.
- instr_rdata_o  out  32  word presented to ID.
- instr_ready_i  in  1  ID takes the word when instr_valid_o & instr_ready_i (handoff).
- flush_i  in  1  pipeline flush (branch/exception); discards the output stage.
- inj_active_o  out  1  the output stage currently holds an injected marker.

## Operation
- State machine with states EMPTY, FULL_INSTR and FULL_MARKER. FULL_MARKER is used only for injected markers; a fetched marker word sits in FULL_INSTR.
- Counter cnt, width $clog2(MAX_BB_LEN):
  - Counts non-marker handoffs since the last marker handoff.
  - Resets to 0 on any marker handoff, whether injected or fetched.
  - Otherwise increments by 1 per handoff.
  - Never exceeds MAX_BB_LEN-1.
- cnt_nxt is the value cnt takes at the end of the current cycle.
- Load slot exists when all of the following hold:
  - the state is EMPTY or a handoff occurs this cycle;
  - flush_i=0.
- Injection condition inj = load slot & (cnt_nxt == MAX_BB_LEN-1).
  - When inj: load MARKER, go to FULL_MARKER, fetch_ready_o=0. No fetch word is consumed.
- Otherwise, in a load slot: fetch_ready_o=1. If fetch_valid_i, load fetch_rdata_i and go to FULL_INSTR; else go to EMPTY.
- fetch_ready_o = load slot & ~inj (combinational).
- Fetched MARKER words pass through unchanged and reset cnt on handoff. There is no double injection.
- instr_rdata_o is held stable while instr_valid_o=1 and there is no handoff.
- Flush:
  - flush_i=1 forces the state to EMPTY next cycle and suppresses loading.
  - cnt is unaffected, because discarded words never reached ID.
  - A handoff in the same cycle as flush still counts.
- inj_active_o = (state == FULL_MARKER).

## Timing
- Reset values:
  - state EMPTY, cnt 0;
  - instr_valid_o 0, instr_rdata_o 0, inj_active_o 0;
  - fetch_ready_o 1 whenever flush_i=0.
- Latency: 1 cycle from fetch handshake to instr_valid_o.
- Throughput: 1 word/cycle with instr_ready_i held high, apart from injected slots.
- Injection cost: exactly 1 bubble on the fetch side per MAX_BB_LEN-1 non-marker handoffs.
- Worst-case spacing: MAX_BB_LEN-1 non-marker handoffs, then MARKER.
- Boundary cases:
  - Reset asserted mid-operation drops any held word, injected or fetched.
  - Simultaneous flush_i and inj: flush wins. No marker is loaded; inj is re-evaluated on the next load slot.

## Configuration
- CV32E40P_LCE_INJ_STATS_EN:
  - Defined: adds output inj_count_o (16 bits). It increments on each injected-marker handoff, saturates at 16'hFFFF, and resets to 0.
  - Undefined: the port is absent and the behaviour is otherwise identical.

## Test plan
- Streaming, MAX_BB_LEN=4:
  - stimulus: fetch_valid_i=1 continuously with non-marker words A,B,C,D,E, instr_ready_i=1;
  - response: ID sees A,B,C,MARKER,D,E; fetch_ready_o=0 in the cycle MARKER is loaded.
- Natural marker:
  - stimulus: stream A,B,MARKER,C,D,E;
  - response: ID sees A,B,MARKER,C,D,E,MARKER. No extra injection after B; cnt=0 after the fetched marker.
- Backpressure:
  - stimulus: instr_ready_i=0 for 5 cycles while word A is held;
  - response: instr_rdata_o=A stable, fetch_ready_o=0, cnt unchanged.
- Flush:
  - stimulus: flush_i=1 with FULL_INSTR(B) and no handoff, after handing off A;
  - response: next cycle instr_valid_o=0 and cnt=1; B is never presented.
- Flush during injection:
  - stimulus: cnt_nxt=3, MAX_BB_LEN=4, flush_i=1;
  - response: no marker is loaded; the marker is loaded on the first load slot after flush deasserts.
- Reset:
  - stimulus: rst_n low while FULL_MARKER;
  - response: instr_valid_o=0, inj_active_o=0 immediately; cnt=0. With the stats macro defined, inj_count_o=0.
